v19_peak_detector: RTL

//  Sits directly after v19_filter and consumes its shaped output sample stream, one sample every clk.
//  It finds each pulse above a threshold and tracks the pulse maximum.
//  For each pulse it emits one event record (amplitude, timestamp, width, flags) over a valid/ready handshake.

---
 rtl/v19_peak_detector.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/v19_peak_detector.sv
// Pulse peak detector: arms above THRESHOLD, tracks the pulse maximum, and emits one
// amplitude/time/width record per pulse over a valid/ready handshake, then holds off.
module v19_peak_detector #(
    parameter int SIZE_FILTER_DATA = 15,
    parameter int THRESHOLD        = 100,
    parameter int HYST             = 8,
    parameter int MAX_WIDTH        = 64,
    parameter int HOLDOFF          = 16,
    parameter int TS_W             = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA:0]   filter_data,
    input  logic                               peak_ready,
    output logic                               peak_valid,
    output logic signed [SIZE_FILTER_DATA:0]   peak_amp,
    output logic        [TS_W-1:0]             peak_time,
    output logic        [7:0]                  peak_width,
    output logic                               peak_tmo,
    output logic        [15:0]                 lost_count
);

    localparam int DW = SIZE_FILTER_DATA + 1;

    // Compare levels are one bit wider than the data so THRESHOLD-HYST cannot wrap.
    localparam logic signed [DW:0] ThrExt = (DW + 1)'(THRESHOLD);
    localparam logic signed [DW:0] LowThr = (DW + 1)'(THRESHOLD - HYST);
    localparam logic [7:0]         MaxW   = 8'(MAX_WIDTH);
    localparam logic [15:0]        HoldLd = 16'(HOLDOFF);

    typedef enum logic [1:0] {StIdle, StTrack, StHoldoff} state_e;

    state_e                 state_q, state_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    logic signed [DW-1:0]   max_q, max_d;
    logic [TS_W-1:0]        max_ts_q, max_ts_d;
    logic [7:0]             width_q, width_d;
    logic [15:0]            hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic signed [DW-1:0]   amp_q, amp_d;
    logic [TS_W-1:0]        time_q, time_d;
    logic [7:0]             pw_q, pw_d;
    logic                   tmo_q, tmo_d;
    logic [15:0]            lost_q, lost_d;

    logic signed [DW:0]     data_ext;
    logic                   above, below;
    logic                   emit, emit_tmo;
    logic [7:0]             width_inc;

    assign data_ext = {filter_data[DW-1], filter_data};
    assign above    = data_ext > ThrExt;
    assign below    = data_ext < LowThr;

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q + TS_W'(1);
        max_d     = max_q;
        max_ts_d  = max_ts_q;
        width_d   = width_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        amp_d     = amp_q;
        time_d    = time_q;
        pw_d      = pw_q;
        tmo_d     = tmo_q;
        lost_d    = lost_q;
        emit      = 1'b0;
        emit_tmo  = 1'b0;
        width_inc = (width_q >= MaxW) ? MaxW : width_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (above) begin
                    max_d    = filter_data;
                    max_ts_d = ts_q;
                    width_d  = 8'd1;
                    state_d  = StTrack;
                end
            end
            StTrack: begin
                if (below) begin
                    // Ending sample is not part of the pulse width.
                    emit    = 1'b1;
                    hold_d  = HoldLd;
                    state_d = StHoldoff;
                end else begin
                    width_d = width_inc;
                    if (filter_data > max_q) begin
                        max_d    = filter_data;
                        max_ts_d = ts_q;
                    end
                    if (width_inc == MaxW) begin
                        emit     = 1'b1;
                        emit_tmo = 1'b1;
                        hold_d   = HoldLd;
                        state_d  = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (hold_q == 16'd0) begin
                    if (below) state_d = StIdle;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (emit) begin
            if (valid_q && !peak_ready) begin
                // Consumer still holds the previous record: drop this one.
                if (lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
            end else begin
                valid_d = 1'b1;
                amp_d   = max_d;
                time_d  = max_ts_d;
                pw_d    = width_d;
                tmo_d   = emit_tmo;
            end
        end else if (valid_q && peak_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ts_q     <= '0;
            max_q    <= '0;
            max_ts_q <= '0;
            width_q  <= '0;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            amp_q    <= '0;
            time_q   <= '0;
            pw_q     <= '0;
            tmo_q    <= 1'b0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            max_q    <= max_d;
            max_ts_q <= max_ts_d;
            width_q  <= width_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            amp_q    <= amp_d;
            time_q   <= time_d;
            pw_q     <= pw_d;
            tmo_q    <= tmo_d;
            lost_q   <= lost_d;
        end
    end

    assign peak_valid = valid_q;
    assign peak_amp   = amp_q;
    assign peak_time  = time_q;
    assign peak_width = pw_q;
    assign peak_tmo   = tmo_q;
    assign lost_count = lost_q;

endmodule
